// File: rtl/uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_pkg
// Description : Shared constants for the UART transmit/receive byte FIFOs:
//               byte width, default depth and drain FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_fifo_pkg;

    localparam int DATA_W              = 8;
    localparam int DEFAULT_FIFO_ADDR_W = 4;

    // Drain FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Bus-side push port, status flags and uart_core transmit
//               handshake of the transmit FIFO, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if
    import uart_fifo_pkg::*;
#(
    parameter int FIFO_ADDR_W = DEFAULT_FIFO_ADDR_W
) ();

    logic                   rst_soft;
    logic                   push;
    logic [DATA_W-1:0]      push_data;
    logic                   full;
    logic                   empty;
    logic [FIFO_ADDR_W:0]   level;
    logic                   overflow;
    logic [DATA_W-1:0]      tx_data;
    logic                   data_write_en;
    logic                   tx_ready;

    // Bus/core side that drives the FIFO
    modport master (
        output rst_soft, push, push_data, tx_ready,
        input  full, empty, level, overflow, tx_data, data_write_en
    );

    // The FIFO itself
    modport slave (
        input  rst_soft, push, push_data, tx_ready,
        output full, empty, level, overflow, tx_data, data_write_en
    );

endinterface
`default_nettype wire

// File: rtl/iob_sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : iob_sync_fifo_mem
// Description : Register-array circular buffer with independent write and
//               read pointers. Head entry is visible combinationally on
//               rd_data; rd_en advances past it. Flags are kept by the user.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_sync_fifo_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clr,
    input  wire logic              wr_en,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic              rd_en,
    output logic      [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // Storage array: no reset needed, contents are only read once written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit byte FIFO ahead of uart_core. Accepts one byte per
//               cycle from the bus and drains it one byte per uart_core frame
//               through the tx_data / data_write_en / tx_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int FIFO_ADDR_W = DEFAULT_FIFO_ADDR_W
) (
    input  wire logic        clk,
    input  wire logic        rst,
    uart_tx_fifo_if.slave    bus
);

    localparam int                   DEPTH     = 1 << FIFO_ADDR_W;
    localparam logic [FIFO_ADDR_W:0] LEVEL_MAX = DEPTH[FIFO_ADDR_W:0];

    logic [1:0]             state;
    logic [FIFO_ADDR_W:0]   level;
    logic [FIFO_ADDR_W:0]   level_next;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic [DATA_W-1:0]      tx_data;
    logic                   data_write_en;
    logic [DATA_W-1:0]      head;
    logic                   pop;
    logic                   wr_accept;

    // A pop commits the head byte; a soft clear suppresses both ports
    assign pop       = (state == ST_IDLE) && !empty && bus.tx_ready && !bus.rst_soft;
    assign wr_accept = bus.push && (!full || pop) && !bus.rst_soft;

    iob_sync_fifo_mem #(
        .ADDR_W (FIFO_ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.rst_soft),
        .wr_en   (wr_accept),
        .wr_data (bus.push_data),
        .rd_en   (pop),
        .rd_data (head)
    );

    // Next occupancy: push and pop together leave it unchanged
    always_comb begin
        level_next = level;
        if (wr_accept && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !wr_accept) begin
            level_next = level - 1'b1;
        end
    end

    // Registered occupancy flags and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (bus.rst_soft) begin
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            level <= level_next;
            full  <= (level_next == LEVEL_MAX);
            empty <= (level_next == '0);
            if (bus.push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Drain FSM: pop in IDLE, strobe in ISSUE, wait for the core to go busy in HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            tx_data       <= '0;
            data_write_en <= 1'b0;
        end else if (bus.rst_soft) begin
            state         <= ST_IDLE;
            tx_data       <= '0;
            data_write_en <= 1'b0;
        end else begin
            data_write_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data       <= head;
                        data_write_en <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Ready still high means the core has not taken the byte yet
                    if (!bus.tx_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.level         = level;
    assign bus.overflow      = overflow;
    assign bus.tx_data       = tx_data;
    assign bus.data_write_en = data_write_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A behavioural uart_core
//               stand-in drops tx_ready for a random number of cycles after
//               each write strobe; expected byte streams come from queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    import uart_fifo_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_fifo_if #(.FIFO_ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo #(.FIFO_ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Core stand-in state
    bit         auto_core     = 1'b0;
    logic       ready_manual  = 1'b1;
    logic       ready_auto    = 1'b1;
    int         busy          = 0;
    int         low_count     = 0;
    int         low_at_strobe = -1;
    int         double_strobes = 0;
    logic [7:0] emitted[$];
    logic [7:0] model[$];

    assign bus.tx_ready = auto_core ? ready_auto : ready_manual;

    // Record every strobed byte; in auto mode go busy for 2..6 cycles
    initial forever begin
        @(negedge clk);
        if (bus.data_write_en === 1'b1) begin
            emitted.push_back(bus.tx_data);
            if (low_count == low_at_strobe) double_strobes++;
            low_at_strobe = low_count;
            if (auto_core) begin
                ready_auto = 1'b0;
                busy = $urandom_range(2, 6);
            end
        end else if (!auto_core) begin
            ready_auto = 1'b1;
            busy = 0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) ready_auto = 1'b1;
        end
    end

    // Count edges where the core is seen busy (or the FIFO is cleared)
    initial forever begin
        @(posedge clk);
        if (bus.tx_ready === 1'b0 || bus.rst_soft === 1'b1) low_count++;
    end

    task automatic wait_emitted(input int n, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (emitted.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rst_soft  = 1'b0;
        bus.push      = 1'b0;
        bus.push_data = 8'h00;
        ready_manual  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.empty, bus.full, bus.level, bus.overflow, bus.data_write_en, bus.tx_data}
                !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_state cycle %0d: empty=%b full=%b level=%0d ovf=%b dwe=%b tx=%02h, required 1 0 0 0 0 00",
                         i, bus.empty, bus.full, bus.level, bus.overflow, bus.data_write_en, bus.tx_data);
            end
        end
    endtask

    task automatic test_single_byte();
        int base;
        base = emitted.size();
        @(negedge clk);
        bus.push = 1'b1; bus.push_data = 8'hA5;
        @(negedge clk);
        bus.push = 1'b0;
        checks++;
        if (bus.data_write_en !== 1'b0 || bus.level !== 5'd1 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL single_after_push: dwe=%b level=%0d empty=%b, required 0 1 0",
                     bus.data_write_en, bus.level, bus.empty);
        end
        @(negedge clk);
        checks++;
        if (bus.data_write_en !== 1'b1 || bus.tx_data !== 8'hA5 || bus.level !== 5'd0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL single_strobe: dwe=%b tx=%02h level=%0d empty=%b, required 1 a5 0 1",
                     bus.data_write_en, bus.tx_data, bus.level, bus.empty);
        end
        @(negedge clk);
        checks++;
        if (bus.data_write_en !== 1'b0 || bus.tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_one_cycle: dwe=%b tx=%02h, required 0 a5", bus.data_write_en, bus.tx_data);
        end
        ready_manual = 1'b0;
        @(negedge clk);
        ready_manual = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (emitted.size() - base != 1) begin
            errors++;
            $display("FAIL single_count: strobes=%0d, required 1", emitted.size() - base);
        end
    endtask

    task automatic test_burst();
        int base;
        bit to;
        auto_core = 1'b0;
        ready_manual = 1'b0;
        model.delete();
        base = emitted.size();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus.push = 1'b1;
            bus.push_data = 8'($urandom);
            model.push_back(bus.push_data);
        end
        @(negedge clk);
        bus.push = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL burst_full: full=%b level=%0d ovf=%b, required 1 16 0", bus.full, bus.level, bus.overflow);
        end
        auto_core = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                model.delete();
                base = emitted.size();
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    bus.push = 1'b1;
                    bus.push_data = 8'($urandom);
                    model.push_back(bus.push_data);
                    if ($urandom_range(0, 1) == 1) begin
                        @(negedge clk);
                        bus.push = 1'b0;
                    end
                end
                @(negedge clk);
                bus.push = 1'b0;
            end
            wait_emitted(base + model.size(), to);
            checks++;
            if (to || emitted.size() - base != model.size()) begin
                errors++;
                $display("FAIL burst_count round %0d: bytes=%0d, required %0d", r, emitted.size() - base, model.size());
            end
            for (int i = 0; i < model.size() && base + i < emitted.size(); i++) begin
                checks++;
                if (emitted[base + i] !== model[i]) begin
                    errors++;
                    $display("FAIL burst_order round %0d idx %0d: got %02h, required %02h", r, i, emitted[base + i], model[i]);
                end
            end
            checks++;
            if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL burst_drained round %0d: level=%0d empty=%b ovf=%b, required 0 1 0",
                         r, bus.level, bus.empty, bus.overflow);
            end
        end
    endtask

    task automatic test_overflow();
        int base;
        bit to;
        auto_core = 1'b0;
        ready_manual = 1'b0;
        model.delete();
        base = emitted.size();
        for (int v = 'h10; v <= 'h20; v++) begin
            @(negedge clk);
            if (v == 'h20) begin
                checks++;
                if (bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_boundary: ovf=%b full=%b after 16 pushes, required 0 1", bus.overflow, bus.full);
                end
            end
            bus.push = 1'b1;
            bus.push_data = 8'(v);
            if (model.size() < DEPTH) model.push_back(8'(v));
        end
        @(negedge clk);
        bus.push = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flags: full=%b level=%0d ovf=%b, required 1 16 1", bus.full, bus.level, bus.overflow);
        end
        auto_core = 1'b1;
        wait_emitted(base + model.size(), to);
        repeat (30) @(negedge clk);
        checks++;
        if (to || emitted.size() - base != model.size()) begin
            errors++;
            $display("FAIL ovf_count: bytes=%0d, required %0d", emitted.size() - base, model.size());
        end
        for (int i = 0; i < model.size() && base + i < emitted.size(); i++) begin
            checks++;
            if (emitted[base + i] !== model[i]) begin
                errors++;
                $display("FAIL ovf_order idx %0d: got %02h, required %02h", i, emitted[base + i], model[i]);
            end
        end
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b, required 1", bus.overflow);
        end
    endtask

    task automatic test_rst_soft();
        int base;
        auto_core = 1'b0;
        ready_manual = 1'b0;
        base = emitted.size();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.push = 1'b1;
            bus.push_data = 8'(8'h60 + i);
        end
        @(negedge clk);
        bus.push = 1'b0;
        @(negedge clk);
        ready_manual = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.level !== 5'd5 || bus.data_write_en !== 1'b1 || bus.tx_data !== 8'h60) begin
            errors++;
            $display("FAIL soft_pre: level=%0d dwe=%b tx=%02h, required 5 1 60", bus.level, bus.data_write_en, bus.tx_data);
        end
        @(negedge clk);
        bus.rst_soft = 1'b1;
        bus.push = 1'b1;
        bus.push_data = 8'h77;
        @(negedge clk);
        bus.rst_soft = 1'b0;
        bus.push = 1'b0;
        checks++;
        if ({bus.level, bus.empty, bus.full, bus.overflow, bus.data_write_en, bus.tx_data}
            !== {5'd0, 1'b1, 1'b0, 1'b1 ^ 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL soft_clear: level=%0d empty=%b full=%b ovf=%b dwe=%b tx=%02h, required 0 1 0 0 0 00",
                     bus.level, bus.empty, bus.full, bus.overflow, bus.data_write_en, bus.tx_data);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (emitted.size() - base != 1) begin
            errors++;
            $display("FAIL soft_quiet: strobes=%0d, required 1", emitted.size() - base);
        end
        bus.push = 1'b1;
        bus.push_data = 8'h33;
        @(negedge clk);
        bus.push = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.data_write_en !== 1'b1 || bus.tx_data !== 8'h33) begin
            errors++;
            $display("FAIL soft_idle: dwe=%b tx=%02h, required 1 33", bus.data_write_en, bus.tx_data);
        end
        ready_manual = 1'b0;
        @(negedge clk);
        ready_manual = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (emitted.size() - base != 2 || emitted[emitted.size() - 1] !== 8'h33) begin
            errors++;
            $display("FAIL soft_stream: strobes=%0d, required 2 ending in 33", emitted.size() - base);
        end
    endtask

    task automatic test_simul_wrap();
        int base;
        bit to;
        auto_core = 1'b0;
        ready_manual = 1'b0;
        model.delete();
        base = emitted.size();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus.push = 1'b1;
            bus.push_data = 8'($urandom);
            model.push_back(bus.push_data);
        end
        @(negedge clk);
        bus.push = 1'b1;
        bus.push_data = 8'h55;
        model.push_back(8'h55);
        auto_core = 1'b1;
        @(negedge clk);
        bus.push = 1'b0;
        checks++;
        if (bus.level !== 5'd16 || bus.overflow !== 1'b0 || bus.full !== 1'b1 || bus.data_write_en !== 1'b1) begin
            errors++;
            $display("FAIL simul_level: level=%0d ovf=%b full=%b dwe=%b, required 16 0 1 1",
                     bus.level, bus.overflow, bus.full, bus.data_write_en);
        end
        wait_emitted(base + model.size(), to);
        checks++;
        if (to || emitted.size() - base != model.size()) begin
            errors++;
            $display("FAIL simul_count: bytes=%0d, required %0d", emitted.size() - base, model.size());
        end
        for (int i = 0; i < model.size() && base + i < emitted.size(); i++) begin
            checks++;
            if (emitted[base + i] !== model[i]) begin
                errors++;
                $display("FAIL simul_order idx %0d: got %02h, required %02h", i, emitted[base + i], model[i]);
            end
        end
        checks++;
        if (bus.level !== 5'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_end: level=%0d ovf=%b, required 0 0", bus.level, bus.overflow);
        end
    endtask

    task automatic test_handshake();
        checks++;
        if (double_strobes !== 0) begin
            errors++;
            $display("FAIL handshake: strobes without tx_ready low in between=%0d, required 0", double_strobes);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_rst_soft();
        test_simul_wrap();
        test_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
